// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM write arbiter: FSM states,
// default timing limits and operand widths of the byte-write engine.
package i2c_pkg;

  // Post-write idle time (5 ms at 50 MHz), start and completion timeouts.
  localparam int unsigned TWR_CYCLES_DEF    = 250000;
  localparam int unsigned START_TIMEOUT_DEF = 16;
  localparam int unsigned DONE_TIMEOUT_DEF  = 500000;

  // Operand widths of the byte-write engine.
  localparam int CTRL_W = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_TWR,
    ST_ACK
  } arb_state_t;

  // Larger of two limits; sizes the shared timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wr_cycle_timer.sv
// Up-counter shared by all timed states of the arbiter. The cycle in which
// load is high is the first clock spent in the new state, so the counter
// restarts at 1 and 'expired' is suppressed during that cycle.
module wr_cycle_timer
#(
  parameter int W = 8
)
(
  input  logic         clk_50M,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_reg;

  // Count clocks since the last load; saturate so a long stay cannot wrap below the limit.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= W'(1);
    end else if (run && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign expired = !load && (cnt_reg >= limit);

endmodule

// File: rtl/i2c_eeprom_wr_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM byte-write engine between two
// requesters. Launches the write, waits for the engine to finish, enforces
// the EEPROM internal write-cycle time and then acknowledges the requester.
module i2c_eeprom_wr_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned TWR_CYCLES    = TWR_CYCLES_DEF,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int unsigned DONE_TIMEOUT  = DONE_TIMEOUT_DEF
)
(
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [CTRL_W-1:0] ctrl0,
  input  logic [CTRL_W-1:0] ctrl1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              ack_err,
  output logic              busy,
  output logic              owner,
  output logic              wr_write,
  output logic [CTRL_W-1:0] wr_control,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  input  logic              write_complete
);

  localparam int TMR_W = $clog2(max_u(DONE_TIMEOUT, TWR_CYCLES) + 1);

  arb_state_t       state_reg;
  logic             err_reg;
  logic             tmr_load_reg;
  logic [TMR_W-1:0] tmr_limit;
  logic             tmr_expired;
  logic             grant_sel;

  // On a tie the requester that did not win last time gets the engine.
  assign grant_sel = (req0 && req1) ? ~owner : req1;

  // Pick the timeout that applies to the current state.
  always_comb begin
    tmr_limit = TMR_W'(TWR_CYCLES);
    case (state_reg)
      ST_LAUNCH:    tmr_limit = TMR_W'(START_TIMEOUT);
      ST_WAIT_DONE: tmr_limit = TMR_W'(DONE_TIMEOUT);
      default:      ;
    endcase
  end

  wr_cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_50M (clk_50M),
    .reset   (reset),
    .load    (tmr_load_reg),
    .run     (busy),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // Arbitration FSM with registered outputs; the timer is reloaded on every state change.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      err_reg      <= 1'b0;
      tmr_load_reg <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      ack_err      <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b1;
      wr_write     <= 1'b0;
      wr_control   <= '0;
      wr_address   <= '0;
      wr_data      <= '0;
    end else begin
      tmr_load_reg <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      ack_err      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A busy engine (e.g. still finishing after our reset) blocks any grant.
          if (write_complete && (req0 || req1)) begin
            owner        <= grant_sel;
            wr_control   <= grant_sel ? ctrl1 : ctrl0;
            wr_address   <= grant_sel ? addr1 : addr0;
            wr_data      <= grant_sel ? data1 : data0;
            wr_write     <= 1'b1;
            busy         <= 1'b1;
            tmr_load_reg <= 1'b1;
            state_reg    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!write_complete) begin
            wr_write     <= 1'b0;
            tmr_load_reg <= 1'b1;
            state_reg    <= ST_WAIT_DONE;
          end else if (tmr_expired) begin
            // Engine never started: report failure without a tWR wait.
            wr_write     <= 1'b0;
            err_reg      <= 1'b1;
            ack0         <= ~owner;
            ack1         <= owner;
            ack_err      <= 1'b1;
            tmr_load_reg <= 1'b1;
            state_reg    <= ST_ACK;
          end
        end
        ST_WAIT_DONE: begin
          if (write_complete) begin
            tmr_load_reg <= 1'b1;
            state_reg    <= ST_TWR;
          end else if (tmr_expired) begin
            err_reg      <= 1'b1;
            ack0         <= ~owner;
            ack1         <= owner;
            ack_err      <= 1'b1;
            tmr_load_reg <= 1'b1;
            state_reg    <= ST_ACK;
          end
        end
        ST_TWR: begin
          if (tmr_expired) begin
            ack0         <= ~owner;
            ack1         <= owner;
            ack_err      <= err_reg;
            tmr_load_reg <= 1'b1;
            state_reg    <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Ack is visible for this single cycle; requests are ignored here.
          err_reg      <= 1'b0;
          busy         <= 1'b0;
          tmr_load_reg <= 1'b1;
          state_reg    <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
